// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array drain path.
//   N, DW         : default column count and per-sum data width
//   tile_state_e  : tile tracking FSM states
package systolic_pkg;

  localparam int N  = 4;
  localparam int DW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tile_state_e;

endpackage

// File: rtl/systolic_output_collector_if.sv
// Result-row stream (valid/ready) leaving the output collector.
//   out_data  : aligned result row, column k at [k*DW +: DW]
//   out_valid : out_data holds a row
//   out_ready : consumer accepts; transfer = out_valid & out_ready
// master = collector side, slave = consumer side.
interface systolic_output_collector_if #(
  parameter int N  = systolic_pkg::N,
  parameter int DW = systolic_pkg::DW
);

  logic [N*DW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a show-ahead head entry.
//   clk, rst      : clock, synchronous active-high reset
//   wr_en/wr_data : write request; accepted when not full, or when full and
//                   a read happens in the same cycle
//   rd_en/rd_data : read request (ignored when empty); rd_data is the head
//                   entry, forced to zero while empty
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count, so
  // clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/systolic_output_collector.sv
// Drain end of the weight-stationary systolic array.
// Re-aligns the skewed partial-sum row (column k lags column 0 by k cycles)
// into whole rows, buffers them in a FIFO and streams them out, while a tile
// FSM counts delivered rows and flags tile completion.
//   clk, rst     : clock, synchronous active-high reset
//   c_flat       : array bottom outputs, column k at [k*DW +: DW]
//   c_valid      : column-0 sum valid this cycle
//   start        : one-cycle pulse, begin a tile (ignored while busy)
//   tile_rows    : rows in the tile, sampled on an accepted start
//   res          : result-row stream (master side)
//   almost_full  : FIFO count >= DEPTH-N, stop issuing c_valid
//   busy         : tile in progress
//   tile_done    : one-cycle pulse after the tile's last row transfers
//   overflow     : sticky, a row was dropped on a full FIFO
module systolic_output_collector #(
  parameter int N     = systolic_pkg::N,
  parameter int DW    = systolic_pkg::DW,
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N*DW-1:0]             c_flat,
  input  logic                        c_valid,
  input  logic                        start,
  input  logic [CW-1:0]               tile_rows,
  systolic_output_collector_if.master res,
  output logic                        almost_full,
  output logic                        busy,
  output logic                        tile_done,
  output logic                        overflow
);

  import systolic_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [N*DW-1:0] aligned;
  logic            wr_en;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  logic            transfer;

  // Deskew: column k waits N-1-k cycles so every column lines up with the
  // last one. The array cannot stall, so the lines shift unconditionally.
  for (genvar k = 0; k < N; k++) begin : g_col
    localparam int D = N - 1 - k;
    if (D == 0) begin : g_direct
      assign aligned[k*DW +: DW] = c_flat[k*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] sr [D];
      // NOTE: sequential state uses non-blocking assignments so every
      // stage samples the previous stage's old value in the same edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= c_flat[k*DW +: DW];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign aligned[k*DW +: DW] = sr[D-1];
    end
  end

  // c_valid travels with column 0, so it needs the full N-1 stage delay.
  if (N > 1) begin : g_vdly
    logic [N-2:0] vsr;
    always_ff @(posedge clk) begin
      if (rst) begin
        vsr <= '0;
      end else begin
        vsr[0] <= c_valid;
        for (int i = 1; i < N-1; i++) vsr[i] <= vsr[i-1];
      end
    end
    assign wr_en = vsr[N-2];
  end else begin : g_vdirect
    assign wr_en = c_valid;
  end

  sync_fifo #(
    .WIDTH (N*DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (aligned),
    .rd_en   (res.out_ready),
    .rd_data (res.out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign res.out_valid = !fifo_empty;
  assign transfer      = res.out_valid && res.out_ready;

  // N slots of headroom cover rows already inside the deskew pipeline.
  assign almost_full = (fifo_count >= (AW+1)'(DEPTH - N));

  always_ff @(posedge clk) begin
    if (rst)                                 overflow <= 1'b0;
    else if (wr_en && fifo_full && !transfer) overflow <= 1'b1;
  end

  // Tile FSM: only transfers seen in RUN count toward the tile.
  tile_state_e   state;
  logic [CW-1:0] rows_q;
  logic [CW-1:0] row_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rows_q    <= '0;
      row_cnt   <= '0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (tile_rows == '0) begin
              tile_done <= 1'b1;
            end else begin
              rows_q  <= tile_rows;
              row_cnt <= '0;
              busy    <= 1'b1;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (transfer) begin
            if (row_cnt == rows_q - 1'b1) begin
              tile_done <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_output_collector.sv
// Self-checking bench for systolic_output_collector (N=4, DW=16, DEPTH=8).
// Skewed rows are generated from a short issue history; every row expected
// to survive is queued at issue time and compared when it leaves the stream.
module tb_systolic_output_collector;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] c_flat;
  logic            c_valid;
  logic            start;
  logic [CW-1:0]   tile_rows;
  logic            almost_full;
  logic            busy;
  logic            tile_done;
  logic            overflow;

  systolic_output_collector_if #(.N(N), .DW(DW)) res_if ();

  systolic_output_collector #(
    .N(N), .DW(DW), .DEPTH(DEPTH), .CW(CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .c_flat      (c_flat),
    .c_valid     (c_valid),
    .start       (start),
    .tile_rows   (tile_rows),
    .res         (res_if),
    .almost_full (almost_full),
    .busy        (busy),
    .tile_done   (tile_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int              total = 0;
  int              bad   = 0;
  logic [N*DW-1:0] exp_q [$];
  logic            hv  [N];
  int              hid [N];

  typedef struct {
    logic v;
    logic exp_valid;
    logic exp_af;
    logic exp_ovf;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] colval(input int id, input int k);
    return DW'(32'h10 + id * 32'h100 + k);
  endfunction

  function automatic logic [N*DW-1:0] row_of(input int id);
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = colval(id, k);
    return r;
  endfunction

  // One array cycle: column k carries the row issued k cycles ago.
  task automatic step(input logic v, input int id, input logic keep);
    for (int k = N-1; k > 0; k--) begin
      hv[k]  = hv[k-1];
      hid[k] = hid[k-1];
    end
    hv[0]  = v;
    hid[0] = id;
    if (v && keep) exp_q.push_back(row_of(id));
    c_valid = v;
    for (int k = 0; k < N; k++)
      c_flat[k*DW +: DW] = hv[k] ? colval(hid[k], k) : 16'hBEEF;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (!rst && res_if.out_valid && res_if.out_ready) begin
      check("row_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("row_data", res_if.out_data, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    c_valid = 1'b0;
    start = 1'b0;
    tile_rows = '0;
    c_flat = '0;
    res_if.out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      hv[k] = 1'b0;
      hid[k] = 0;
    end
    for (int c = 0; c < 15; c++) begin
      tbl[c].v         = (c < 12);
      tbl[c].exp_valid = (c >= 3);
      tbl[c].exp_af    = (c >= 6);
      tbl[c].exp_ovf   = (c >= 11);
    end

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 64'(res_if.out_valid), 64'd0);
    check("rst_out_data", res_if.out_data, 64'd0);
    check("rst_almost_full", 64'(almost_full), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);

    // Single row latency: out_valid in cycle 4.
    for (int c = 0; c < 4; c++) begin
      step(c == 0, 0, 1'b1);
      check($sformatf("lat_valid_c%0d", c + 1), 64'(res_if.out_valid), 64'(c == 3));
    end
    check("lat_data", res_if.out_data, 64'h0013_0012_0011_0010);
    res_if.out_ready = 1'b1;
    step(1'b0, 0, 1'b0);
    check("lat_drained", 64'(res_if.out_valid), 64'd0);

    // Eight back-to-back rows in a tile of eight.
    tile_rows = 16'd8;
    start = 1'b1;
    step(1'b0, 0, 1'b0);
    start = 1'b0;
    check("t2_busy_start", 64'(busy), 64'd1);
    for (int c = 0; c < 14; c++) begin
      step(c < 8, c + 1, 1'b1);
      check($sformatf("t2_done_c%0d", c), 64'(tile_done), 64'(c == 11));
      check($sformatf("t2_busy_c%0d", c), 64'(busy), 64'(c < 11));
      check($sformatf("t2_valid_c%0d", c), 64'(res_if.out_valid), 64'(c >= 3 && c <= 10));
    end
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Fill with no reader: almost_full, full, drops, overflow.
    res_if.out_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step(tbl[c].v, 16 + c, c < 8);
      check($sformatf("t3_valid_c%0d", c), 64'(res_if.out_valid), 64'(tbl[c].exp_valid));
      check($sformatf("t3_af_c%0d", c), 64'(almost_full), 64'(tbl[c].exp_af));
      check($sformatf("t3_ovf_c%0d", c), 64'(overflow), 64'(tbl[c].exp_ovf));
    end
    res_if.out_ready = 1'b1;
    repeat (9) step(1'b0, 0, 1'b0);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t3_drained", 64'(res_if.out_valid), 64'd0);
    check("t3_ovf_sticky", 64'(overflow), 64'd1);

    // Reset mid-tile with 3 rows buffered and 2 in the deskew lines.
    res_if.out_ready = 1'b0;
    tile_rows = 16'd5;
    start = 1'b1;
    step(1'b0, 0, 1'b0);
    start = 1'b0;
    check("t6_busy", 64'(busy), 64'd1);
    for (int c = 0; c < 6; c++) step(c < 5, 40 + c, 1'b1);
    check("t6_buffered", 64'(res_if.out_valid), 64'd1);
    rst = 1'b1;
    step(1'b0, 0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    check("t6_valid", 64'(res_if.out_valid), 64'd0);
    check("t6_busy_clr", 64'(busy), 64'd0);
    check("t6_ovf_clr", 64'(overflow), 64'd0);
    check("t6_af_clr", 64'(almost_full), 64'd0);
    res_if.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 0, 1'b0);
      check($sformatf("t6_stale_c%0d", c), 64'(res_if.out_valid), 64'd0);
      check($sformatf("t6_done_c%0d", c), 64'(tile_done), 64'd0);
    end

    // Full FIFO: write and read in the same cycle keeps every row.
    res_if.out_ready = 1'b0;
    for (int c = 0; c < 11; c++) step(c < 8, 60 + c, 1'b1);
    check("t4_full_af", 64'(almost_full), 64'd1);
    check("t4_full_valid", 64'(res_if.out_valid), 64'd1);
    check("t4_full_ovf", 64'(overflow), 64'd0);
    for (int c = 11; c < 14; c++) step(c == 11, 68, 1'b1);
    res_if.out_ready = 1'b1;
    step(1'b0, 0, 1'b0);
    res_if.out_ready = 1'b0;
    check("t4_no_drop", 64'(overflow), 64'd0);
    check("t4_still_full", 64'(almost_full), 64'd1);
    res_if.out_ready = 1'b1;
    repeat (9) step(1'b0, 0, 1'b0);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t4_drained", 64'(res_if.out_valid), 64'd0);

    // Zero-row tile, then a start ignored while busy.
    tile_rows = 16'd0;
    start = 1'b1;
    step(1'b0, 0, 1'b0);
    start = 1'b0;
    check("t5_zero_done", 64'(tile_done), 64'd1);
    check("t5_zero_busy", 64'(busy), 64'd0);
    step(1'b0, 0, 1'b0);
    check("t5_zero_pulse", 64'(tile_done), 64'd0);
    tile_rows = 16'd2;
    start = 1'b1;
    step(1'b0, 0, 1'b0);
    start = 1'b0;
    check("t5_busy", 64'(busy), 64'd1);
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin
        start = 1'b1;
        tile_rows = 16'd5;
      end
      step(c == 0 || c == 3, (c == 0) ? 80 : 81, 1'b1);
      start = 1'b0;
      check($sformatf("t5_done_c%0d", c), 64'(tile_done), 64'(c == 7));
      check($sformatf("t5_busy_c%0d", c), 64'(busy), 64'(c < 7));
    end
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
